cacheline_adapter: RTL
======================

# cacheline_adapter

Converts whole-cacheline transactions from the cache arbiter into fixed-length bursts on the physical memory port. On the arbiter side it sees one 256-bit line read or write and returns a single-cycle response. On the memory side it drives a burst of 64-bit beats, advanced one beat per `pmem_resp`. It sits directly downstream of the arbiter and is the only master of physical memory.

## Interface
- `cacheline_size`, 256, line width in bits.
- `burst_width`, 64, memory beat width in bits. BEATS = `cacheline_size`/`burst_width`; BEATS must be an integer ≥ 2 (4 by default).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adapter_read`  in  1  line read request; held until `adapter_resp`.
- `adapter_write`  in  1  line write request; held until `adapter_resp`.
- `adapter_address`  in  32  request byte address.
- `adapter_wdata`  in  `cacheline_size`  line to write.
- `adapter_resp`  out  1  one-cycle completion pulse.
- `adapter_rdata`  out  `cacheline_size`  assembled read line.
- `pmem_read`  out  1  burst read strobe.
- `pmem_write`  out  1  burst write strobe.
- `pmem_address`  out  32  line-aligned burst address.
- `pmem_wdata`  out  `burst_width`  current write beat.
- `pmem_rdata`  in  `burst_width`  current read beat.
- `pmem_resp`  in  1  beat accepted (write) or valid (read).

## Operation
The block is a four-state FSM (IDLE, READ, WRITE, DONE) with a beat counter `cnt` of width clog2(BEATS), a latched address register, and a line buffer `buf` of width `cacheline_size`.

- **IDLE**
  - If `adapter_write` is high: latch `adapter_wdata` into `buf`, latch the aligned address, set `cnt`=0, go to WRITE. Write wins when read and write are both high; the read stays pending and is serviced later as a new transaction.
  - Else if `adapter_read` is high: latch the aligned address, set `cnt`=0, go to READ.
  - Otherwise stay in IDLE.
- **Aligned address**: {`adapter_address`[31:clog2(`cacheline_size`/8)], zeros}. This clears bits [4:0] at the default parameters.
- **READ**
  - `pmem_read`=1.
  - On `pmem_resp`: write `pmem_rdata` into `buf`[`cnt`*`burst_width` +: `burst_width`] and increment `cnt`. Beat 0 is the least-significant slice.
  - On the beat where `cnt`==BEATS-1 and `pmem_resp` is high, go to DONE.
- **WRITE**
  - `pmem_write`=1.
  - `pmem_wdata` = `buf`[`cnt`*`burst_width` +: `burst_width`].
  - On `pmem_resp`, increment `cnt`. After the last beat, go to DONE.
- **DONE**
  - `adapter_resp`=1 for exactly one cycle, then go to IDLE unconditionally.
- **Outputs by state**: `pmem_read` and `pmem_write` are low in IDLE and DONE, and never high together. `pmem_address` outputs the latched address in READ and WRITE, and 0 otherwise.
- **Read data**: `adapter_rdata` = `buf`. It is valid in DONE and holds its value until the next transaction modifies `buf`.
- **Ignored inputs**: `pmem_resp` is ignored in IDLE and DONE. Request-input changes are ignored in READ, WRITE and DONE.
- **Reset**: `rst` forces IDLE, `cnt`=0, `buf`=0 and address=0 on the next edge, from any state including mid-burst. A partially completed burst is abandoned, and no `adapter_resp` is issued for it.

## Timing
- **Reset values**: `adapter_resp`=0, `adapter_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0.
- **Request acceptance**: a request sampled in IDLE at edge N drives `pmem_read` or `pmem_write` from cycle N+1.
- **Latency**: with the final `pmem_resp` at cycle M, `adapter_resp` is high in cycle M+1 only. Minimum latency, with back-to-back beats from cycle N+1, is BEATS+2 cycles from request to response.
- **Beat spacing**: stall cycles between beats (`pmem_resp`=0) hold `cnt`, `buf` and all strobes unchanged.
- **Back-to-back transactions**: the arbiter returns to its idle state after `adapter_resp`, so a new request arrives no earlier than DONE+2. The block is already in IDLE by then. The cycle immediately after DONE is therefore always IDLE.
- **Combinational paths**: none from `adapter_*` inputs to `pmem_*` outputs. All memory-side outputs are functions of state and registers only.

## Test plan
- **Reset**: assert `rst` for 2 cycles -> all outputs 0 and state IDLE; `pmem_resp` pulses while idle leave everything unchanged.
- **Read, no stalls**: read at 0x1234_5678; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> `pmem_address`=0x1234_5660 and `adapter_resp` pulses exactly once, BEATS+2 cycles after the request. `adapter_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Read with stalls**: 3 idle cycles between every beat -> same line, `adapter_resp` one cycle after the 4th `pmem_resp`, `pmem_read` continuously high until then.
- **Write**: write line {0xD..D, 0xC..C, 0xB..B, 0xA..A} to 0x8000_001F -> `pmem_address`=0x8000_0000 and `pmem_wdata` presents 0xA..A, 0xB..B, 0xC..C, 0xD..D, each held until its `pmem_resp`. `pmem_read` stays 0 throughout, and `adapter_resp` pulses once.
- **Simultaneous read and write**: both high in IDLE -> WRITE burst runs first, then DONE, then IDLE. With read still held, a READ burst follows.
- **Reset mid-burst**: `rst` after beat 2 of a read -> strobes drop next cycle and no `adapter_resp` is issued. A fresh read afterwards returns a complete and correct line.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: arbiter-side line port and memory-side burst port of the cacheline adapter.
interface cacheline_adapter_if #(parameter int CACHELINE_SIZE = 256, parameter int BURST_WIDTH = 64);
   logic                      adapter_read;
   logic                      adapter_write;
   logic [31:0]               adapter_address;
   logic [CACHELINE_SIZE-1:0] adapter_wdata;
   logic                      adapter_resp;
   logic [CACHELINE_SIZE-1:0] adapter_rdata;
   logic                      pmem_read;
   logic                      pmem_write;
   logic [31:0]               pmem_address;
   logic [BURST_WIDTH-1:0]    pmem_wdata;
   logic [BURST_WIDTH-1:0]    pmem_rdata;
   logic                      pmem_resp;
   modport master (
      input  adapter_read, adapter_write, adapter_address, adapter_wdata, pmem_rdata, pmem_resp,
      output adapter_resp, adapter_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
   modport slave (
      output adapter_read, adapter_write, adapter_address, adapter_wdata, pmem_rdata, pmem_resp,
      input  adapter_resp, adapter_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns whole-line arbiter reads/writes into fixed-length beat bursts on physical memory.
module cacheline_adapter #(parameter int CACHELINE_SIZE = 256, parameter int BURST_WIDTH = 64) (
   input logic                clk,
   input logic                rst,
   cacheline_adapter_if.master bus
);
   localparam int BEATS = CACHELINE_SIZE / BURST_WIDTH;
   localparam int CW = $clog2(BEATS);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t                    r_state, w_next;
   logic [CW-1:0]             r_cnt;
   logic [31:0]               r_addr, w_aligned;
   logic [CACHELINE_SIZE-1:0] r_buf;
   logic                      w_last;
   assign w_aligned = bus.adapter_address & ~32'(CACHELINE_SIZE / 8 - 1);
   assign w_last = r_cnt == CW'(BEATS - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_buf   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (bus.adapter_write) begin
                  r_buf  <= bus.adapter_wdata;
                  r_addr <= w_aligned;
                  r_cnt  <= '0;
               end else if (bus.adapter_read) begin
                  r_addr <= w_aligned;
                  r_cnt  <= '0;
               end
            end
            READ: begin
               if (bus.pmem_resp) begin
                  r_buf[r_cnt*BURST_WIDTH +: BURST_WIDTH] <= bus.pmem_rdata;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WRITE: begin
               if (bus.pmem_resp) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        w_next = bus.adapter_write ? WRITE : bus.adapter_read ? READ : IDLE;
         READ, WRITE: w_next = (bus.pmem_resp && w_last) ? DONE : r_state;
         default:     w_next = IDLE;
      endcase
   end
   // Memory-side outputs depend only on state and registers, never on adapter inputs.
   assign bus.pmem_read     = r_state == READ;
   assign bus.pmem_write    = r_state == WRITE;
   assign bus.pmem_address  = (r_state == READ || r_state == WRITE) ? r_addr : 32'h0;
   assign bus.pmem_wdata    = r_buf[r_cnt*BURST_WIDTH +: BURST_WIDTH];
   assign bus.adapter_resp  = r_state == DONE;
   assign bus.adapter_rdata = r_buf;
endmodule
